// File: rtl/ship_placer.sv
// Fleet placement controller: cursor/rotate editing, bounds and overlap check, board write-out.
// Build option: define CURSOR_WRAP_EN to make cursor moves wrap at the board edges.
module ship_placer #(
   parameter int GRID_SIZE = 10,
   parameter int NUM_SHIPS = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_rotate,
   input  logic       btn_place,
   output logic [7:0] cursor,
   output logic [3:0] orientation,
   output logic [3:0] length,
   output logic       wr_en,
   output logic [7:0] wr_addr,
   output logic       busy,
   output logic       place_err,
   output logic       all_placed
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_EDIT  = 3'd1;
   localparam logic [2:0] S_CHECK = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [3:0] O_N = 4'd1;
   localparam logic [3:0] O_E = 4'd2;
   localparam logic [3:0] O_S = 4'd4;
   localparam logic [3:0] O_W = 4'd8;

   localparam logic [3:0] GMAX = 4'(GRID_SIZE - 1);
   localparam logic [2:0] LAST = 3'(NUM_SHIPS - 1);

   logic [2:0]   state;
   logic [3:0]   cx, cy, orient_reg, k;
   logic [2:0]   ship_idx;
   logic [255:0] occ;
   logic [3:0]   nx, ny;
   logic [7:0]   cur_addr, first_addr, next_addr;
   logic         cur_bad;

   function automatic logic [3:0] len_of(input logic [2:0] i);
      case (i)
         3'd0:    len_of = 4'd5;
         3'd1:    len_of = 4'd4;
         3'd2:    len_of = 4'd3;
         3'd3:    len_of = 4'd3;
         3'd4:    len_of = 4'd2;
         default: len_of = 4'd0;
      endcase
   endfunction

   // Low nibbles of the wrapped 4-bit sums equal the true cell coordinates
   // whenever the cell is in range; oob_of decides range separately.
   function automatic logic [7:0] addr_of(input logic [3:0] x, input logic [3:0] y,
                                          input logic [3:0] o, input logic [3:0] i);
      case (o)
         O_N:     addr_of = {x, y - i};
         O_E:     addr_of = {x + i, y};
         O_S:     addr_of = {x, y + i};
         O_W:     addr_of = {x - i, y};
         default: addr_of = {x, y};
      endcase
   endfunction

   function automatic logic oob_of(input logic [3:0] x, input logic [3:0] y,
                                   input logic [3:0] o, input logic [3:0] i);
      logic signed [5:0] sx, sy, si, lim;
      sx  = $signed({2'b00, x});
      sy  = $signed({2'b00, y});
      si  = $signed({2'b00, i});
      lim = $signed({2'b00, GMAX});
      case (o)
         O_N:     sy = sy - si;
         O_E:     sx = sx + si;
         O_S:     sy = sy + si;
         O_W:     sx = sx - si;
         default: ;
      endcase
      oob_of = (sx < 0) || (sx > lim) || (sy < 0) || (sy > lim);
   endfunction

   assign cur_addr   = addr_of(cx, cy, orient_reg, k);
   assign first_addr = addr_of(cx, cy, orient_reg, 4'd0);
   assign next_addr  = addr_of(cx, cy, orient_reg, k + 4'd1);
   assign cur_bad    = oob_of(cx, cy, orient_reg, k) || occ[cur_addr];

   always_comb begin
      nx = cx;
      ny = cy;
      priority case (1'b1)
`ifdef CURSOR_WRAP_EN
         btn_up:    ny = (cy == 4'd0) ? GMAX : cy - 4'd1;
         btn_down:  ny = (cy == GMAX) ? 4'd0 : cy + 4'd1;
         btn_left:  nx = (cx == 4'd0) ? GMAX : cx - 4'd1;
         btn_right: nx = (cx == GMAX) ? 4'd0 : cx + 4'd1;
`else
         btn_up:    ny = (cy == 4'd0) ? cy : cy - 4'd1;
         btn_down:  ny = (cy == GMAX) ? cy : cy + 4'd1;
         btn_left:  nx = (cx == 4'd0) ? cx : cx - 4'd1;
         btn_right: nx = (cx == GMAX) ? cx : cx + 4'd1;
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         cx         <= 4'd0;
         cy         <= 4'd0;
         orient_reg <= O_E;
         k          <= 4'd0;
         ship_idx   <= 3'd0;
         occ        <= '0;
         wr_en      <= 1'b0;
         wr_addr    <= 8'h00;
         place_err  <= 1'b0;
      end else begin
         place_err <= 1'b0;
         case (state)
            S_IDLE, S_DONE, S_EDIT: begin
               if (start) begin
                  state      <= S_EDIT;
                  cx         <= 4'd0;
                  cy         <= 4'd0;
                  orient_reg <= O_E;
                  k          <= 4'd0;
                  ship_idx   <= 3'd0;
                  occ        <= '0;
               end else if (state == S_EDIT) begin
                  if (btn_place) begin
                     state <= S_CHECK;
                     k     <= 4'd0;
                  end else if (btn_rotate) begin
                     orient_reg <= {orient_reg[2:0], orient_reg[3]};
                  end else begin
                     cx <= nx;
                     cy <= ny;
                  end
               end
            end
            S_CHECK: begin
               if (cur_bad) begin
                  place_err <= 1'b1;
                  state     <= S_EDIT;
                  k         <= 4'd0;
               end else if (k == length - 4'd1) begin
                  state   <= S_WRITE;
                  k       <= 4'd0;
                  wr_en   <= 1'b1;
                  wr_addr <= first_addr;
               end else begin
                  k <= k + 4'd1;
               end
            end
            S_WRITE: begin
               occ[wr_addr] <= 1'b1;
               if (k == length - 4'd1) begin
                  wr_en    <= 1'b0;
                  k        <= 4'd0;
                  ship_idx <= ship_idx + 3'd1;
                  state    <= (ship_idx == LAST) ? S_DONE : S_EDIT;
               end else begin
                  k       <= k + 4'd1;
                  wr_addr <= next_addr;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign cursor      = {cx, cy};
   assign length      = len_of(ship_idx);
   assign busy        = (state == S_CHECK) || (state == S_WRITE);
   assign all_placed  = (state == S_DONE);
   assign orientation = (state == S_EDIT || busy) ? orient_reg : 4'd0;

endmodule

// File: tb/tb_ship_placer.sv
// Directed bench for ship_placer: vector table for editing, sequences for placement and reset.
// Expected cursor values follow the CURSOR_WRAP_EN build option.
module tb_ship_placer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
   logic       btn_rotate = 1'b0, btn_place = 1'b0;
   logic [7:0] cursor, wr_addr;
   logic [3:0] orientation, length;
   logic       wr_en, busy, place_err, all_placed;

   ship_placer dut (
      .clk(clk), .rst(rst), .start(start),
      .btn_up(btn_up), .btn_down(btn_down),
      .btn_left(btn_left), .btn_right(btn_right),
      .btn_rotate(btn_rotate), .btn_place(btn_place),
      .cursor(cursor), .orientation(orientation), .length(length),
      .wr_en(wr_en), .wr_addr(wr_addr), .busy(busy),
      .place_err(place_err), .all_placed(all_placed)
   );

   always #5 clk = ~clk;

   localparam logic [6:0] B_START = 7'b1000000;
   localparam logic [6:0] B_PLACE = 7'b0100000;
   localparam logic [6:0] B_ROT   = 7'b0010000;
   localparam logic [6:0] B_UP    = 7'b0001000;
   localparam logic [6:0] B_DN    = 7'b0000100;
   localparam logic [6:0] B_LF    = 7'b0000010;
   localparam logic [6:0] B_RT    = 7'b0000001;
`ifdef CURSOR_WRAP_EN
   localparam logic [7:0] L0 = 8'h90;
   localparam logic [7:0] U0 = 8'h09;
`else
   localparam logic [7:0] L0 = 8'h00;
   localparam logic [7:0] U0 = 8'h00;
`endif

   typedef struct {
      logic [6:0] b;
      logic [7:0] cur;
      logic [3:0] ori;
      logic [3:0] len;
   } vec_t;

   vec_t vt[17];

   int n_cmp = 0;
   int n_bad = 0;
   int bx = 0, by = 0;
   int r_chk, r_nwr;
   bit r_err, r_to;
   logic [7:0] r_addr[8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic press(input logic [6:0] b);
      {start, btn_place, btn_rotate, btn_up, btn_down, btn_left, btn_right} = b;
      tick();
      {start, btn_place, btn_rotate, btn_up, btn_down, btn_left, btn_right} = '0;
   endtask

   task automatic move_to(input int tx, input int ty);
      while (bx < tx) begin press(B_RT); bx++; end
      while (bx > tx) begin press(B_LF); bx--; end
      while (by < ty) begin press(B_DN); by++; end
      while (by > ty) begin press(B_UP); by--; end
   endtask

   task automatic do_place();
      press(B_PLACE);
      r_chk = 0; r_nwr = 0; r_err = 0; r_to = 1;
      for (int i = 0; i < 40; i++) begin
         if (place_err) begin r_err = 1; r_to = 0; break; end
         if (!busy) begin r_to = 0; break; end
         if (wr_en) begin
            if (r_nwr < 8) r_addr[r_nwr] = wr_addr;
            r_nwr++;
         end else begin
            r_chk++;
         end
         tick();
      end
   endtask

   task automatic check_place(input string nm, input int echk, input bit eerr,
                              input int en, input logic [39:0] ea);
      do_place();
      chk({nm, "_timeout"}, 32'(r_to), 32'd0);
      chk({nm, "_check_cycles"}, 32'(r_chk), 32'(echk));
      chk({nm, "_err"}, 32'(r_err), 32'(eerr));
      chk({nm, "_writes"}, 32'(r_nwr), 32'(en));
      for (int i = 0; i < en && i < 5; i++)
         chk({nm, "_addr"}, 32'(r_addr[i]), 32'(ea[39-8*i -: 8]));
   endtask

   initial begin
      vt[0]  = '{B_RT,         8'h00, 4'd0, 4'd5};
      vt[1]  = '{B_START,      8'h00, 4'd2, 4'd5};
      vt[2]  = '{B_LF,         L0,    4'd2, 4'd5};
      vt[3]  = '{B_START,      8'h00, 4'd2, 4'd5};
      vt[4]  = '{B_UP,         U0,    4'd2, 4'd5};
      vt[5]  = '{B_START,      8'h00, 4'd2, 4'd5};
      vt[6]  = '{B_RT,         8'h10, 4'd2, 4'd5};
      vt[7]  = '{B_RT,         8'h20, 4'd2, 4'd5};
      vt[8]  = '{B_DN,         8'h21, 4'd2, 4'd5};
      vt[9]  = '{B_ROT,        8'h21, 4'd4, 4'd5};
      vt[10] = '{B_ROT | B_UP, 8'h21, 4'd8, 4'd5};
      vt[11] = '{B_ROT,        8'h21, 4'd1, 4'd5};
      vt[12] = '{B_ROT,        8'h21, 4'd2, 4'd5};
      vt[13] = '{B_LF | B_RT,  8'h11, 4'd2, 4'd5};
      vt[14] = '{B_DN | B_LF,  8'h12, 4'd2, 4'd5};
      vt[15] = '{B_UP | B_DN,  8'h11, 4'd2, 4'd5};
      vt[16] = '{B_START,      8'h00, 4'd2, 4'd5};

      tick();
      tick();
      rst = 1'b0;
      chk("rst_cursor", 32'(cursor), 32'h00);
      chk("rst_orient", 32'(orientation), 32'd0);
      chk("rst_length", 32'(length), 32'd5);
      chk("rst_wr_en", 32'(wr_en), 32'd0);
      chk("rst_wr_addr", 32'(wr_addr), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err", 32'(place_err), 32'd0);
      chk("rst_done", 32'(all_placed), 32'd0);

      for (int i = 0; i < 17; i++) begin
         press(vt[i].b);
         chk($sformatf("vec%0d_cursor", i), 32'(cursor), 32'(vt[i].cur));
         chk($sformatf("vec%0d_orient", i), 32'(orientation), 32'(vt[i].ori));
         chk($sformatf("vec%0d_length", i), 32'(length), 32'(vt[i].len));
         chk($sformatf("vec%0d_busy", i), 32'(busy), 32'd0);
      end
      bx = 0; by = 0;

      check_place("ship1", 5, 1'b0, 5, 40'h0010203040);
      chk("ship1_len_after", 32'(length), 32'd4);

      check_place("overlap", 1, 1'b1, 0, 40'h0);
      chk("overlap_orient", 32'(orientation), 32'd2);
      chk("overlap_cursor", 32'(cursor), 32'h00);
      chk("overlap_len", 32'(length), 32'd4);

      move_to(8, 0);
      press(B_ROT); press(B_ROT); press(B_ROT);
      chk("north_orient", 32'(orientation), 32'd1);
      move_to(8, 2);
      check_place("north_oob", 4, 1'b1, 0, 40'h0);
      chk("north_oob_cursor", 32'(cursor), 32'h82);
      chk("north_oob_orient", 32'(orientation), 32'd1);
      move_to(8, 8);
      check_place("north_ok", 4, 1'b0, 4, 40'h8887868500);
      chk("north_ok_len", 32'(length), 32'd3);

      press(B_ROT);
      move_to(0, 2);
      check_place("ship3", 3, 1'b0, 3, 40'h0212220000);
      move_to(0, 4);
      check_place("ship4", 3, 1'b0, 3, 40'h0414240000);
      move_to(0, 6);
      check_place("ship5", 2, 1'b0, 2, 40'h0616000000);
      chk("done_flag", 32'(all_placed), 32'd1);
      chk("done_orient", 32'(orientation), 32'd0);
      press(B_RT);
      chk("done_ignore_move", 32'(cursor), 32'h06);
      press(B_PLACE);
      chk("done_ignore_place", 32'(busy), 32'd0);
      chk("done_still", 32'(all_placed), 32'd1);

      press(B_START);
      bx = 0; by = 0;
      chk("restart_done", 32'(all_placed), 32'd0);
      chk("restart_len", 32'(length), 32'd5);
      chk("restart_orient", 32'(orientation), 32'd2);
      chk("restart_cursor", 32'(cursor), 32'h00);
      check_place("cleared", 5, 1'b0, 5, 40'h0010203040);

      move_to(0, 1);
      press(B_PLACE);
      r_to = 1;
      for (int i = 0; i < 20; i++) begin
         if (wr_en) begin r_to = 0; break; end
         tick();
      end
      chk("midwr_timeout", 32'(r_to), 32'd0);
      tick();
      chk("midwr_second", 32'(wr_en), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midwr_cursor", 32'(cursor), 32'h00);
      chk("midwr_orient", 32'(orientation), 32'd0);
      chk("midwr_len", 32'(length), 32'd5);
      chk("midwr_wr_en", 32'(wr_en), 32'd0);
      chk("midwr_wr_addr", 32'(wr_addr), 32'd0);
      chk("midwr_busy", 32'(busy), 32'd0);
      chk("midwr_err", 32'(place_err), 32'd0);
      chk("midwr_done", 32'(all_placed), 32'd0);
      press(B_RT);
      chk("idle_ignore_move", 32'(cursor), 32'h00);
      press(B_PLACE);
      chk("idle_ignore_place", 32'(busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
